// File: rtl/steer_controller.sv
// steer_controller: line-following motor steering for the clk_video domain.
// Turns each frame's line centroid into a signed steering correction, clamps
// per-wheel duty, and drives two PWM outputs whose duty only changes at the
// period wrap. Coasts, then searches, when the line is lost.
// Optional build macro: STEER_DERIV_EN adds the KD derivative term.
module steer_controller #(
    parameter  int IMG_W       = 640,
    parameter  int PWM_PERIOD  = 1000,
    parameter  int BASE_DUTY   = 600,
    parameter  int KP          = 2,
    parameter  int KD          = 1,
    parameter  int OUT_SHIFT   = 3,
    parameter  int LOST_FRAMES = 4,
    parameter  int SEARCH_DUTY = 300,
    localparam int DW          = $clog2(PWM_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [10:0]   centroid_x,
    input  logic          line_valid,
    input  logic          line_lost,
    input  logic          in_ready,
    output logic          pwm_left,
    output logic          pwm_right,
    output logic [DW-1:0] duty_left,
    output logic [DW-1:0] duty_right,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, COAST = 2'd2, SEARCH = 2'd3} st_t;

    localparam int LW = $clog2(LOST_FRAMES + 1);
`ifdef STEER_DERIV_EN
    localparam bit DERIV_ON = 1'b1;
`else
    localparam bit DERIV_ON = 1'b0;
`endif
    localparam logic signed [11:0] HALF_S = 12'(IMG_W / 2);
    localparam logic signed [23:0] KP_S   = 24'(KP);
    localparam logic signed [23:0] KD_S   = 24'(KD);
    localparam logic signed [24:0] BASE_S = 25'(BASE_DUTY);
    localparam logic signed [24:0] PER_S  = 25'(PWM_PERIOD);

    // Saturate a signed duty request into 0..PWM_PERIOD.
    function automatic logic [DW-1:0] clamp_duty(input logic signed [24:0] v);
        if (v < 25'sd0)
            return '0;
        else if (v > PER_S)
            return DW'(PWM_PERIOD);
        else
            return v[DW-1:0];
    endfunction

    // Stage p0: capture the strobe, error and line classification.
    logic                vld_p0;
    logic signed [11:0]  err_p0;
    logic                ok_p0;

    // Strobe qualifier is control and follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= in_ready;
    end

    // Error and line-ok flag are pure data; a frame is usable only when valid and not lost.
    always_ff @(posedge clk) begin
        err_p0 <= signed'({1'b0, centroid_x}) - HALF_S;
        ok_p0  <= line_valid & ~line_lost;
    end

    // Stage p1: correction, clamped targets and the tracking FSM.
    st_t                 state_q;
    st_t                 st_eff;
    logic signed [11:0]  prev_err;
    logic [LW-1:0]       lost_cnt;
    logic [LW-1:0]       lost_nxt;
    logic [DW-1:0]       tgt_l;
    logic [DW-1:0]       tgt_r;
    logic signed [23:0]  err_w;
    logic signed [23:0]  prev_w;
    logic signed [23:0]  sum;
    logic signed [23:0]  corr;
    logic [DW-1:0]       calc_l;
    logic [DW-1:0]       calc_r;

    // An enabled IDLE acts as TRACK so a strobe arriving on the enabling edge is not lost.
    // Without the derivative build KD_S is gated off and only the sign of prev_err matters.
    always_comb begin
        st_eff   = (state_q == IDLE) ? TRACK : state_q;
        lost_nxt = (st_eff == TRACK) ? LW'(1) : lost_cnt + LW'(1);
        err_w    = {{12{err_p0[11]}}, err_p0};
        prev_w   = (st_eff == SEARCH) ? 24'sd0 : {{12{prev_err[11]}}, prev_err};
        sum      = KP_S * err_w;
        if (DERIV_ON)
            sum = sum + KD_S * (err_w - prev_w);
        corr     = sum >>> OUT_SHIFT;
        calc_l   = clamp_duty(BASE_S + {corr[23], corr});
        calc_r   = clamp_duty(BASE_S - {corr[23], corr});
    end

    // Tracking FSM: valid frames update targets, lost frames coast then search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tgt_l    <= '0;
            tgt_r    <= '0;
            prev_err <= '0;
            lost_cnt <= '0;
        end else if (!enable) begin
            state_q  <= IDLE;
            tgt_l    <= '0;
            tgt_r    <= '0;
            prev_err <= '0;
            lost_cnt <= '0;
        end else begin
            state_q <= st_eff;
            if (vld_p0) begin
                if (ok_p0) begin
                    state_q  <= TRACK;
                    tgt_l    <= calc_l;
                    tgt_r    <= calc_r;
                    prev_err <= err_p0;
                    lost_cnt <= '0;
                end else if (st_eff != SEARCH) begin
                    lost_cnt <= lost_nxt;
                    if (lost_nxt >= LW'(LOST_FRAMES)) begin
                        state_q <= SEARCH;
                        if (prev_err[11]) begin
                            tgt_l <= '0;
                            tgt_r <= DW'(SEARCH_DUTY);
                        end else begin
                            tgt_l <= DW'(SEARCH_DUTY);
                            tgt_r <= '0;
                        end
                    end else begin
                        state_q <= COAST;
                    end
                end
            end
        end
    end

    assign state = state_q;

    // Stage p2: PWM period counter with shadowed duty registers.
    logic [DW-1:0] pwm_cnt;
    logic [DW-1:0] cnt_nxt;
    logic [DW-1:0] duty_l_nxt;
    logic [DW-1:0] duty_r_nxt;
    logic          wrap;

    // Duty only moves at the wrap; a disabled block loads zero there.
    always_comb begin
        wrap       = (pwm_cnt == DW'(PWM_PERIOD - 1));
        cnt_nxt    = wrap ? '0 : pwm_cnt + DW'(1);
        duty_l_nxt = duty_left;
        duty_r_nxt = duty_right;
        if (wrap) begin
            duty_l_nxt = enable ? tgt_l : '0;
            duty_r_nxt = enable ? tgt_r : '0;
        end
    end

    // PWM outputs are registered from next-cycle counter/duty so pwm_x == (counter < duty_x).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt    <= '0;
            duty_left  <= '0;
            duty_right <= '0;
            pwm_left   <= 1'b0;
            pwm_right  <= 1'b0;
        end else begin
            pwm_cnt    <= cnt_nxt;
            duty_left  <= duty_l_nxt;
            duty_right <= duty_r_nxt;
            pwm_left   <= (cnt_nxt < duty_l_nxt);
            pwm_right  <= (cnt_nxt < duty_r_nxt);
        end
    end

endmodule

// File: tb/tb_steer_controller.sv
// Bench for steer_controller: table of frame strobes with expected state and
// per-wheel duty, plus hand sequences for back-to-back strobes, saturation,
// disable and asynchronous reset.
module tb_steer_controller;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          enable2;
    logic [10:0]   centroid_x;
    logic          line_valid;
    logic          line_lost;
    logic          in_ready;
    logic          pwm_left, pwm_right;
    logic [DW-1:0] duty_left, duty_right;
    logic [1:0]    state;
    logic          pwm2_l, pwm2_r;
    logic [DW-1:0] duty2_l, duty2_r;
    logic [1:0]    state2;

    steer_controller dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost), .in_ready(in_ready),
        .pwm_left(pwm_left), .pwm_right(pwm_right), .duty_left(duty_left),
        .duty_right(duty_right), .state(state)
    );

    steer_controller #(.OUT_SHIFT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost), .in_ready(in_ready),
        .pwm_left(pwm2_l), .pwm_right(pwm2_r), .duty_left(duty2_l),
        .duty_right(duty2_r), .state(state2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cx;
        bit v;
        bit l;
        int st;
        int dl;
        int dr;
    } vec_t;

    typedef struct {
        int st;
        int dl;
        int dr;
    } exp_t;

    localparam int NV = 17;
    vec_t tbl [NV];
    exp_t sbq [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int cx, input bit v, input bit l);
        centroid_x = 11'(cx);
        line_valid = v;
        line_lost  = l;
        in_ready   = 1'b1;
        tick();
        in_ready   = 1'b0;
        line_valid = 1'b0;
        line_lost  = 1'b0;
    endtask

    // Wait past the next wrap, pop the oldest expectation, check duty and PWM high count.
    task automatic settle_and_check(input string tag);
        exp_t e;
        int   hl, hr;
        repeat (1003) tick();
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        check({tag, "_state"}, int'(state), e.st);
        check({tag, "_duty_l"}, int'(duty_left), e.dl);
        check({tag, "_duty_r"}, int'(duty_right), e.dr);
        hl = 0;
        hr = 0;
        for (int k = 0; k < 1000; k++) begin
            hl += int'(pwm_left);
            hr += int'(pwm_right);
            tick();
        end
        check({tag, "_pwm_l_high"}, hl, e.dl);
        check({tag, "_pwm_r_high"}, hr, e.dr);
    endtask

    initial begin
        int  hl, hr;
        bit  done;

        // Expected state / duty after each strobe in sequence.
`ifdef STEER_DERIV_EN
        tbl[0]  = '{320, 1, 0, 1, 600, 600};
        tbl[1]  = '{400, 1, 0, 1, 630, 570};
        tbl[2]  = '{0,   0, 1, 2, 630, 570};
        tbl[3]  = '{0,   0, 1, 2, 630, 570};
        tbl[4]  = '{0,   1, 1, 2, 630, 570};
        tbl[5]  = '{0,   0, 0, 3, 300, 0};
        tbl[6]  = '{0,   0, 1, 3, 300, 0};
        tbl[7]  = '{320, 1, 0, 1, 600, 600};
        tbl[8]  = '{200, 1, 0, 1, 555, 645};
        tbl[9]  = '{0,   0, 1, 2, 555, 645};
        tbl[10] = '{316, 1, 0, 1, 613, 587};
        tbl[11] = '{0,   0, 1, 2, 613, 587};
        tbl[12] = '{0,   0, 1, 2, 613, 587};
        tbl[13] = '{0,   0, 1, 2, 613, 587};
        tbl[14] = '{0,   0, 1, 3, 0, 300};
        tbl[15] = '{0,   1, 0, 1, 480, 720};
        tbl[16] = '{639, 1, 0, 1, 759, 441};
`else
        tbl[0]  = '{320, 1, 0, 1, 600, 600};
        tbl[1]  = '{400, 1, 0, 1, 620, 580};
        tbl[2]  = '{0,   0, 1, 2, 620, 580};
        tbl[3]  = '{0,   0, 1, 2, 620, 580};
        tbl[4]  = '{0,   1, 1, 2, 620, 580};
        tbl[5]  = '{0,   0, 0, 3, 300, 0};
        tbl[6]  = '{0,   0, 1, 3, 300, 0};
        tbl[7]  = '{320, 1, 0, 1, 600, 600};
        tbl[8]  = '{200, 1, 0, 1, 570, 630};
        tbl[9]  = '{0,   0, 1, 2, 570, 630};
        tbl[10] = '{316, 1, 0, 1, 599, 601};
        tbl[11] = '{0,   0, 1, 2, 599, 601};
        tbl[12] = '{0,   0, 1, 2, 599, 601};
        tbl[13] = '{0,   0, 1, 2, 599, 601};
        tbl[14] = '{0,   0, 1, 3, 0, 300};
        tbl[15] = '{0,   1, 0, 1, 520, 680};
        tbl[16] = '{639, 1, 0, 1, 679, 521};
`endif

        rst_n      = 1'b0;
        enable     = 1'b0;
        enable2    = 1'b0;
        centroid_x = '0;
        line_valid = 1'b0;
        line_lost  = 1'b0;
        in_ready   = 1'b0;
        repeat (3) tick();
        check("rst_state", int'(state), 0);
        check("rst_duty_l", int'(duty_left), 0);
        check("rst_duty_r", int'(duty_right), 0);
        check("rst_pwm", int'({pwm_left, pwm_right}), 0);

        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        repeat (2) tick();
        check("enable_track", int'(state), 1);

        for (int i = 0; i < NV; i++) begin
            strobe(tbl[i].cx, tbl[i].v, tbl[i].l);
            sbq.push_back('{tbl[i].st, tbl[i].dl, tbl[i].dr});
            settle_and_check($sformatf("v%0d", i));
        end

        // Back-to-back strobes: valid 400 then lost on the very next cycle.
        centroid_x = 11'd400;
        line_valid = 1'b1;
        line_lost  = 1'b0;
        in_ready   = 1'b1;
        tick();
        line_valid = 1'b0;
        line_lost  = 1'b1;
        tick();
        in_ready   = 1'b0;
        line_lost  = 1'b0;
        repeat (2) tick();
        check("b2b_state_early", int'(state), 2);
`ifdef STEER_DERIV_EN
        sbq.push_back('{2, 590, 610});
`else
        sbq.push_back('{2, 620, 580});
`endif
        settle_and_check("b2b");

        // Saturation on the OUT_SHIFT=0 instance: left pinned high, right pinned low.
        enable2 = 1'b1;
        strobe(639, 1'b1, 1'b0);
        repeat (1003) tick();
        check("sat_state", int'(state2), 1);
        check("sat_duty_l", int'(duty2_l), 1000);
        check("sat_duty_r", int'(duty2_r), 0);
        hl = 0;
        hr = 0;
        for (int k = 0; k < 1000; k++) begin
            hl += int'(pwm2_l);
            hr += int'(pwm2_r);
            tick();
        end
        check("sat_pwm_l_high", hl, 1000);
        check("sat_pwm_r_high", hr, 0);

        // Disable while tracking: IDLE next cycle, PWM quiet within one period.
        enable = 1'b0;
        tick();
        check("dis_state", int'(state), 0);
        done = 1'b0;
        for (int k = 0; k < 1001 && !done; k++) begin
            if (duty_left == '0 && duty_right == '0 && !pwm_left && !pwm_right)
                done = 1'b1;
            else
                tick();
        end
        check("dis_within_period", int'(done), 1);
        hl = 0;
        hr = 0;
        for (int k = 0; k < 1000; k++) begin
            hl += int'(pwm_left);
            hr += int'(pwm_right);
            tick();
        end
        check("dis_pwm_l_high", hl, 0);
        check("dis_pwm_r_high", hr, 0);

        // Asynchronous reset while pwm_left is high.
        enable = 1'b1;
        strobe(320, 1'b1, 1'b0);
        repeat (1003) tick();
        done = 1'b0;
        for (int k = 0; k < 1001 && !done; k++) begin
            if (pwm_left)
                done = 1'b1;
            else
                tick();
        end
        check("arst_pwm_seen_high", int'(done), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", int'({pwm_left, pwm_right}), 0);
        check("arst_state", int'(state), 0);
        check("arst_duty_l", int'(duty_left), 0);
        check("arst_duty_r", int'(duty_right), 0);
        enable = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", int'(state), 0);
        check("post_rst_pwm", int'({pwm_left, pwm_right}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
